// File: rtl/ram_byte_tx_pkg.sv
// Shared types and constants for the RAM-to-Xmega byte transmitter.
// Holds the FSM state encoding and the reset values of the TX bus.
package ram_byte_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StLow,
        StHigh,
        StDone
    } state_e;

    localparam int unsigned BytesPerWord = 8;
    localparam logic [7:0]  TxDataRst    = 8'h00;
    localparam logic        TxClkRst     = 1'b0;

endpackage

// File: rtl/ram_byte_tx_byte_strobe_tx.sv
// Drives one byte onto the TX bus with a DIV-cycle low phase then a DIV-cycle high strobe.
// A load while the high phase ends drops the strobe and presents the next byte on one edge.
module ram_byte_tx_byte_strobe_tx
    import ram_byte_tx_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic [7:0] tx_data_o,
    output logic       tx_clk_o,
    output logic       half_done_o,
    output logic       byte_done_o
);

    localparam logic [7:0] Reload = 8'(DIV - 1);

    logic       active_q, active_d;
    logic       tx_clk_q, tx_clk_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] cnt_q, cnt_d;

    assign half_done_o = active_q && !tx_clk_q && (cnt_q == 8'd0);
    assign byte_done_o = active_q && tx_clk_q && (cnt_q == 8'd0);
    assign tx_data_o   = tx_data_q;
    assign tx_clk_o    = tx_clk_q;

    always_comb begin
        active_d  = active_q;
        tx_clk_d  = tx_clk_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            active_d  = 1'b1;
            tx_clk_d  = 1'b0;
            tx_data_d = byte_i;
            cnt_d     = Reload;
        end else if (active_q) begin
            if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else if (!tx_clk_q) begin
                tx_clk_d = 1'b1;
                cnt_d    = Reload;
            end else begin
                // Byte finished with no follow-on: strobe drops, data holds.
                tx_clk_d = 1'b0;
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q  <= 1'b0;
            tx_clk_q  <= TxClkRst;
            tx_data_q <= TxDataRst;
            cnt_q     <= 8'd0;
        end else begin
            active_q  <= active_d;
            tx_clk_q  <= tx_clk_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_byte_tx.sv
// Reads 64-bit words from sync RAM and sends each as 8 strobed bytes, MSB byte first.
// The FSM sequences RAM reads and word/byte counts; the strobe sub-module times each byte.
module ram_byte_tx
    import ram_byte_tx_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WORD_W = 64,
    parameter int unsigned DIV    = 4
) (
    input  logic              CLK_50,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_data,
    output logic [7:0]        TX_DATA,
    output logic              TX_CLK,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;

    logic                load;
    logic [7:0]          load_byte;
    logic                half_done;
    logic                byte_done;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        load       = 1'b0;
        load_byte  = shift_q[WORD_W-1 -: 8];
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d = StRead;
                        addr_d  = base_addr;
                        words_d = num_words;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                // RAM data is valid now; first byte goes out as LOW is entered.
                state_d    = StLow;
                load       = 1'b1;
                load_byte  = ram_data[WORD_W-1 -: 8];
                shift_d    = {ram_data[WORD_W-9:0], 8'h00};
                byte_cnt_d = 3'd0;
            end
            StLow: begin
                if (half_done) state_d = StHigh;
            end
            StHigh: begin
                if (byte_done) begin
                    if (byte_cnt_q != 3'(BytesPerWord - 1)) begin
                        state_d    = StLow;
                        load       = 1'b1;
                        shift_d    = {shift_q[WORD_W-9:0], 8'h00};
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end else if (words_q > (ADDR_W+1)'(1)) begin
                        state_d = StRead;
                        words_d = words_q - (ADDR_W+1)'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        ram_rd_en_d = (state_d == StRead);
        ram_addr_d  = (state_d == StRead) ? addr_d : ram_addr_q;
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            words_q     <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            ram_rd_en_q <= 1'b0;
            ram_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            ram_rd_en_q <= ram_rd_en_d;
            ram_addr_q  <= ram_addr_d;
        end
    end

    ram_byte_tx_byte_strobe_tx #(
        .DIV (DIV)
    ) u_strobe (
        .clk_i       (CLK_50),
        .rst_i       (RST),
        .load_i      (load),
        .byte_i      (load_byte),
        .tx_data_o   (TX_DATA),
        .tx_clk_o    (TX_CLK),
        .half_done_o (half_done),
        .byte_done_o (byte_done)
    );

    assign ram_rd_en = ram_rd_en_q;
    assign ram_addr  = ram_addr_q;
    assign busy      = (state_q == StRead) || (state_q == StWait) ||
                       (state_q == StLow)  || (state_q == StHigh);
    assign done      = (state_q == StDone);

endmodule

// File: doc/ram_byte_tx.md
Name: ram_byte_tx

Overview:
FPGA-to-Xmega return path. Reads 64-bit words from the local sync RAM, serializes each word into 8 bytes on a dedicated 8-bit output bus, and generates a strobe clock. The Xmega samples the bus on each strobe rising edge, the same convention the FPGA uses when sampling CM on CLK_inter. Byte order matches the inbound shift-left packer: a word sent here and re-packed by a shift-left receiver is reproduced bit-exact.

Parameters:
ADDR_W, 4, RAM address width (16 words)
WORD_W, 64, RAM word width; fixed at 8 bytes
DIV, 4, CLK_50 cycles per strobe half-period; legal range 1..255

Ports:
CLK_50  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
base_addr  input  ADDR_W  first RAM address, captured on accepted start
num_words  input  ADDR_W+1  words to send, 0..16, captured on accepted start
ram_rd_en  output  1  RAM read enable (registered)
ram_addr  output  ADDR_W  RAM read address (registered)
ram_data  input  WORD_W  RAM read data, valid 1 cycle after ram_rd_en
TX_DATA  output  8  byte bus to Xmega
TX_CLK  output  1  strobe; Xmega samples TX_DATA on rising edge
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset: state IDLE, TX_DATA=0, TX_CLK=0, ram_rd_en=0, ram_addr=0, busy=0, done=0, counters cleared. Reset mid-transfer aborts at once. No further strobe edges; an incomplete byte is never completed.
- States: IDLE, READ, WAIT, LOW, HIGH, DONE.
- IDLE: start=1 and num_words!=0 -> READ; capture base_addr, num_words; busy=1 next cycle.
- IDLE: start=1 and num_words==0 -> DONE. No RAM read, no strobe edge.
- start while busy: ignored, no effect on the transfer in progress.
- READ (1 cycle): ram_rd_en=1, ram_addr=current address -> WAIT.
- WAIT (1 cycle): ram_rd_en=0 -> LOW. On LOW entry, ram_data loads into a 64-bit shift register and TX_DATA=ram_data[63:56].
- LOW (DIV cycles): TX_CLK=0, TX_DATA stable -> HIGH.
- HIGH (DIV cycles): TX_CLK=1, TX_DATA stable. At exit:
  - bytes remain in word: shift left 8, TX_DATA=next top byte, TX_CLK falls the same cycle -> LOW.
  - 8th byte done, words remain: address+1 mod 2^ADDR_W (wraps 15->0) -> READ, TX_CLK=0.
  - last word done -> DONE.
- DONE (1 cycle): done=1, busy=0, TX_CLK=0, TX_DATA holds last byte -> IDLE.
- TX_DATA changes only while TX_CLK is low, or on the same edge that TX_CLK falls. It never changes on a rising strobe edge.
- Timing per word: 2 + 16*DIV cycles (66 at DIV=4). 8 rising strobe edges per word.
- Total N words: accepted start + N*(2+16*DIV) cycles, then done pulse.
- Half-period counter is 8 bits, reloaded with DIV-1 on each state entry.

Decomposition:
- Shared package: state enum (IDLE/READ/WAIT/LOW/HIGH/DONE), BYTES_PER_WORD=8, reset constants for TX outputs.
- One natural sub-module: byte_strobe_tx.
  - Inputs: load, 8-bit byte.
  - Behaviour: produces the LOW/HIGH strobe phase timing; returns byte_done.
  - Parent FSM owns RAM sequencing and word/byte counting.

Test Plan:
- Reset, then 1 word at addr 3 = 0x0123456789ABCDEF, DIV=4 -> 8 TX_CLK rising edges sample 01,23,45,67,89,AB,CD,EF. done pulses exactly 66 cycles after start accepted. A shift-left receiver model reproduces 0x0123456789ABCDEF.
- base_addr=14, num_words=4 -> ram_addr sequence 14,15,0,1. 32 bytes in order. busy high throughout; single done pulse.
- num_words=0 -> no ram_rd_en, no TX_CLK edge. done=1 in the cycle after start, busy never asserts.
- start re-pulsed during byte 3 of a 2-word transfer -> ignored. Exactly 16 bytes sent, one done.
- RST asserted while TX_CLK=1 mid-byte 5 -> next cycle TX_CLK=0, TX_DATA=0, busy=0, no done. A fresh start afterwards transmits the full word from byte 0.
- DIV=1, 16 words of 0xFFFFFFFF00000000 -> strobe period 2 cycles. Bytes alternate FF×4, 00×4. TX_DATA never changes on a TX_CLK rising edge (assertion checked). Total 16*18 cycles.
